// File: rtl/datapath_sw_pkg.sv
// Shared definitions for the multicycle store-word datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package datapath_sw_pkg;

    // Control sequence of one instruction
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEMADR = 3'd3,
        S_MEMWR  = 3'd4
    } state_t;

    // The only executable opcode, and the all-ones stop word
    localparam logic [5:0]  OP_SW      = 6'b101011;
    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

    // MIPS I-type field positions
    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int IMM_LO = 0;

    // Byte stride between consecutive instructions
    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/datapath_sw_mc_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port, r0 reads as zero.
// Latency: reads combinational; a write is visible to reads on the cycle after it is clocked.
// Backpressure: none; a write is always accepted when we=1 (writes to r0 are dropped).
import datapath_sw_pkg::*;

module sw_regfile #(
    parameter int M = 32,
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [N-1:0] wa,
    input  logic [M-1:0] wd,
    input  logic [N-1:0] ra1,
    output logic [M-1:0] rd1,
    input  logic [N-1:0] ra2,
    output logic [M-1:0] rd2
);

    logic [M-1:0] regs [0:(2**N)-1];

    // Clear all registers on reset; otherwise commit writes to any register but r0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2**N; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    // r0 is forced to zero at the read mux so its storage content never matters
    always_comb begin
        rd1 = (ra1 == '0) ? '0 : regs[ra1];
        rd2 = (ra2 == '0) ? '0 : regs[ra2];
    end

endmodule

// File: rtl/datapath_sw_mc.sv
// Multicycle SW datapath: fetch, decode, address-generate and store over one shared req/ack bus.
// Latency: 4 cycles per zero-wait SW (FETCH, DECODE, MEMADR, MEMWR), plus 1 cycle per ack wait state.
// Backpressure: bus request and payload held until mem_ack; the FSM stalls in FETCH/MEMWR until then.
// Optional: DATAPATH_SW_ALIGN_CHECK_EN adds a word-alignment check that turns a misaligned SW into err.
import datapath_sw_pkg::*;

module datapath_sw_mc #(
    parameter int             M        = 32,
    parameter int             N        = 5,
    parameter int             O        = 16,
    parameter logic [M-1:0]   RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run,
    input  logic         rf_we_ext,
    input  logic [N-1:0] rf_wa_ext,
    input  logic [M-1:0] rf_wd_ext,
    output logic         mem_req,
    output logic         mem_we,
    output logic [M-1:0] mem_addr,
    output logic [M-1:0] mem_wdata,
    input  logic [M-1:0] mem_rdata,
    input  logic         mem_ack,
    output logic [M-1:0] pc_out,
    output logic [15:0]  retired,
    output logic         err,
    output logic         done
);

    state_t       state;
    state_t       state_nx;

    logic [M-1:0] pc;
    logic [M-1:0] ir;
    logic [M-1:0] a_reg;
    logic [M-1:0] b_reg;
    logic [M-1:0] alu_out;
    logic [15:0]  retired_q;

    // Load strobes raised by the control FSM
    logic         ir_ld;
    logic         pc_inc;
    logic         ab_ld;
    logic         alu_ld;
    logic         ret_inc;

    logic [N-1:0] rs_idx;
    logic [N-1:0] rt_idx;
    logic [M-1:0] rd_rs;
    logic [M-1:0] rd_rt;
    logic [M-1:0] imm_ext;
    logic [M-1:0] alu_sum;
    logic         is_halt;
    logic         is_sw;
    logic         rf_we;

    assign rs_idx  = N'(ir[RS_HI:RS_LO]);
    assign rt_idx  = N'(ir[RT_HI:RT_LO]);
    assign imm_ext = {{(M-O){ir[IMM_LO+O-1]}}, ir[IMM_LO +: O]};
    assign alu_sum = a_reg + imm_ext;
    assign is_halt = (ir == HALT_INSTR);
    assign is_sw   = (ir[OP_HI:OP_LO] == OP_SW);

    // Preload port is only live while the machine is parked
    assign rf_we   = rf_we_ext && (state == S_IDLE);

    assign pc_out  = pc;
    assign retired = retired_q;

    sw_regfile #(
        .M (M),
        .N (N)
    ) u_regfile (
        .clk (clk),
        .rst (rst),
        .we  (rf_we),
        .wa  (rf_wa_ext),
        .wd  (rf_wd_ext),
        .ra1 (rs_idx),
        .rd1 (rd_rs),
        .ra2 (rt_idx),
        .rd2 (rd_rt)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, bus outputs and datapath strobes; bus outputs are decoded from state
    // so an asynchronous reset drops mem_req in the same instant
    always_comb begin
        state_nx  = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        err       = 1'b0;
        done      = 1'b0;
        ir_ld     = 1'b0;
        pc_inc    = 1'b0;
        ab_ld     = 1'b0;
        alu_ld    = 1'b0;
        ret_inc   = 1'b0;
        case (state)
            S_IDLE: begin
                if (run) begin
                    state_nx = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc;
                if (mem_ack) begin
                    ir_ld    = 1'b1;
                    pc_inc   = 1'b1;
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                ab_ld = 1'b1;
                if (is_halt) begin
                    done     = 1'b1;
                    state_nx = S_IDLE;
                end else if (is_sw) begin
                    state_nx = S_MEMADR;
                end else begin
                    // Unknown opcode: skip it, PC already points past it
                    err      = 1'b1;
                    state_nx = run ? S_FETCH : S_IDLE;
                end
            end
            S_MEMADR: begin
                alu_ld   = 1'b1;
                state_nx = S_MEMWR;
`ifdef DATAPATH_SW_ALIGN_CHECK_EN
                // Misaligned word store is dropped before it reaches the bus
                if (alu_sum[1:0] != 2'b00) begin
                    err      = 1'b1;
                    state_nx = run ? S_FETCH : S_IDLE;
                end
`endif
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = alu_out;
                mem_wdata = b_reg;
                if (mem_ack) begin
                    ret_inc  = 1'b1;
                    state_nx = run ? S_FETCH : S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Datapath registers: PC, IR, operand latches, address latch and retire counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            ir        <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            alu_out   <= '0;
            retired_q <= '0;
        end else begin
            if (ir_ld) begin
                ir <= mem_rdata;
            end
            if (pc_inc) begin
                pc <= pc + M'(INSTR_BYTES);
            end
            if (ab_ld) begin
                a_reg <= rd_rs;
                b_reg <= rd_rt;
            end
            if (alu_ld) begin
                alu_out <= alu_sum;
            end
            if (ret_inc) begin
                retired_q <= retired_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_datapath_sw_mc.sv
// Bench for datapath_sw_mc: ISA-level reference model feeds an event scoreboard,
// a bus responder with fixed or random ack delay serves fetches, and a monitor
// checks every fetch, store, err and done against the expected event stream.
module tb_datapath_sw_mc;

    localparam int M = 32;
    localparam int N = 5;

    localparam int EV_FETCH = 0;
    localparam int EV_WRITE = 1;
    localparam int EV_ERR   = 2;
    localparam int EV_DONE  = 3;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         run;
    logic         rf_we_ext;
    logic [N-1:0] rf_wa_ext;
    logic [M-1:0] rf_wd_ext;
    logic         mem_req;
    logic         mem_we;
    logic [M-1:0] mem_addr;
    logic [M-1:0] mem_wdata;
    logic [M-1:0] mem_rdata;
    logic         mem_ack;
    logic [M-1:0] pc_out;
    logic [15:0]  retired;
    logic         err;
    logic         done;

    ev_t          sb[$];
    logic [31:0]  mem [logic [31:0]];
    logic [31:0]  mregs [32];
    logic [31:0]  prog [$];
    logic [31:0]  exp_pc;
    int           exp_ret;

    int           n_checks = 0;
    int           n_err    = 0;
    int           ack_mode = 0;   // <0: random 0..3 wait states per transfer
    bit           spurious = 1'b0;
    bit           garbage  = 1'b0;

    // Monitor history for bus-hold checks
    logic         p_req, p_ack, p_we;
    logic [31:0]  p_addr, p_wd;

    // Responder state
    bit           in_x;
    int           wcnt;
    int           wcur;

    datapath_sw_mc dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .rf_we_ext (rf_we_ext),
        .rf_wa_ext (rf_wa_ext),
        .rf_wd_ext (rf_wd_ext),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .pc_out    (pc_out),
        .retired   (retired),
        .err       (err),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_sw(input int rt, input int rs, input logic [15:0] imm);
        logic [4:0] rs5;
        logic [4:0] rt5;
        rs5 = rs[4:0];
        rt5 = rt[4:0];
        return {6'b101011, rs5, rt5, imm};
    endfunction

    // Compare one observed bus/pulse event with the oldest expected one
    task automatic observe(input int kind, input logic [31:0] addr, input logic [31:0] data);
        ev_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_event: got kind %0d addr %h data %h, expected no event", kind, addr, data);
        end else begin
            e = sb.pop_front();
            chk("ev_kind", 32'(kind), 32'(e.kind));
            if (e.kind == EV_FETCH || e.kind == EV_WRITE) chk("ev_addr", addr, e.addr);
            if (e.kind == EV_WRITE) chk("ev_wdata", data, e.data);
        end
    endtask

    // ISA-level interpretation of the loaded program into the expected event stream
    task automatic setup_program();
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] addr;
        bit          mis;
        mem.delete();
        for (int i = 0; i < prog.size(); i++) mem[32'(i * 4)] = prog[i];
        pc = 32'h0;
        for (int i = 0; i < prog.size(); i++) begin
            ins = prog[i];
            sb.push_back('{EV_FETCH, pc, 32'h0});
            pc = pc + 32'd4;
            if (ins == HALT) begin
                sb.push_back('{EV_DONE, 32'h0, 32'h0});
                break;
            end else if (ins[31:26] == 6'b101011) begin
                addr = mregs[ins[25:21]] + {{16{ins[15]}}, ins[15:0]};
                mis  = 1'b0;
`ifdef DATAPATH_SW_ALIGN_CHECK_EN
                mis  = (addr[1:0] != 2'b00);
`endif
                if (mis) begin
                    sb.push_back('{EV_ERR, 32'h0, 32'h0});
                end else begin
                    sb.push_back('{EV_WRITE, addr, mregs[ins[20:16]]});
                    exp_ret++;
                end
            end else begin
                sb.push_back('{EV_ERR, 32'h0, 32'h0});
            end
        end
        exp_pc = pc;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        run       = 1'b0;
        rf_we_ext = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        exp_ret = 0;
    endtask

    task automatic preload(input int wa, input logic [31:0] wd);
        @(negedge clk);
        rf_we_ext = 1'b1;
        rf_wa_ext = wa[4:0];
        rf_wd_ext = wd;
        @(negedge clk);
        rf_we_ext = 1'b0;
        if (wa != 0) mregs[wa] = wd;
    endtask

    // Run until done; cyc counts cycles from the first fetch through the first store ack
    task automatic wait_done(input string tag, output int cyc);
        bit started;
        bit measured;
        bit got;
        started  = 1'b0;
        measured = 1'b0;
        got      = 1'b0;
        cyc      = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i == 0 && garbage) begin
                rf_we_ext = 1'b1;
                rf_wa_ext = 5'($urandom);
                rf_wd_ext = $urandom;
            end
            if (mem_req) started = 1'b1;
            if (started && !measured) cyc++;
            if (mem_req && mem_we && mem_ack) measured = 1'b1;
            if (done) begin
                run       = 1'b0;
                rf_we_ext = 1'b0;
                got       = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_err++;
            $display("FAIL %s_timeout: got no done pulse, expected one within 3000 cycles", tag);
            run       = 1'b0;
            rf_we_ext = 1'b0;
        end
    endtask

    task automatic exec(input string tag, output int cyc);
        @(negedge clk);
        run = 1'b1;
        wait_done(tag, cyc);
        repeat (2) @(negedge clk);
        chk({tag, "_pc"}, pc_out, exp_pc);
        chk({tag, "_retired"}, 32'(retired), 32'(exp_ret & 16'hFFFF));
        chk({tag, "_idle_req"}, 32'(mem_req), 32'h0);
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'h0);
    endtask

    // Bus responder: decides ack shortly after each rising edge
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        in_x      = 1'b0;
        wcnt      = 0;
        wcur      = 0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_req) begin
                if (!in_x) begin
                    in_x = 1'b1;
                    wcnt = 0;
                    wcur = (ack_mode < 0) ? int'($urandom_range(0, 3)) : ack_mode;
                end
                if (wcnt >= wcur) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_we ? $urandom
                                       : (mem.exists(mem_addr) ? mem[mem_addr] : HALT);
                    in_x      = 1'b0;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                    wcnt++;
                end
            end else begin
                in_x      = 1'b0;
                mem_ack   = spurious && ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
        end
    end

    // Monitor: pops the scoreboard on every completed transfer or pulse
    initial begin
        p_req  = 1'b0;
        p_ack  = 1'b0;
        p_we   = 1'b0;
        p_addr = 32'h0;
        p_wd   = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                p_req = 1'b0;
                p_ack = 1'b0;
            end else begin
                if (mem_req && p_req && !p_ack) begin
                    chk("hold_we", 32'(mem_we), 32'(p_we));
                    chk("hold_addr", mem_addr, p_addr);
                    chk("hold_wdata", mem_wdata, p_wd);
                end
                if (mem_req && mem_ack) begin
                    if (mem_we) observe(EV_WRITE, mem_addr, mem_wdata);
                    else        observe(EV_FETCH, mem_addr, 32'h0);
                end
                if (err)  observe(EV_ERR, 32'h0, 32'h0);
                if (done) observe(EV_DONE, 32'h0, 32'h0);
                p_req  = mem_req;
                p_ack  = mem_ack;
                p_we   = mem_we;
                p_addr = mem_addr;
                p_wd   = mem_wdata;
            end
        end
    end

    initial begin
        int          cyc;
        int          n;
        int          rs;
        int          rt;
        bit          got;
        logic [5:0]  op;
        logic [15:0] imm;
        logic [31:0] v;

        rst       = 1'b1;
        run       = 1'b0;
        rf_we_ext = 1'b0;
        rf_wa_ext = '0;
        rf_wd_ext = '0;
        exp_ret   = 0;
        exp_pc    = 32'h0;
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_retired", 32'(retired), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        rst = 1'b0;

        // Basic store, zero-wait bus
        do_reset();
        ack_mode = 0;
        preload(1, 32'h0000_0100);
        preload(2, 32'hDEAD_BEEF);
        prog.delete();
        prog.push_back(32'hAC22_0008);
        prog.push_back(HALT);
        setup_program();
        exec("zw", cyc);
        chk("zw_cycles", 32'(cyc), 32'd4);

        // Same program with three wait states on every transfer
        do_reset();
        ack_mode = 3;
        preload(1, 32'h0000_0100);
        preload(2, 32'hDEAD_BEEF);
        setup_program();
        exec("ws3", cyc);
        chk("ws3_cycles", 32'(cyc), 32'd10);

        // Negative offset
        do_reset();
        ack_mode = -1;
        preload(1, 32'h0000_0200);
        preload(3, 32'h1234_5678);
        prog.delete();
        prog.push_back(enc_sw(3, 1, 16'hFFFC));
        prog.push_back(HALT);
        setup_program();
        exec("neg", cyc);

        // Illegal opcode is skipped
        do_reset();
        ack_mode = 0;
        preload(1, 32'h0000_0100);
        preload(2, 32'h5555_AAAA);
        prog.delete();
        prog.push_back(32'h8C22_0000);
        prog.push_back(HALT);
        setup_program();
        exec("ill", cyc);

        // Misaligned store address
        do_reset();
        preload(1, 32'h0000_0101);
        preload(2, 32'hCAFE_F00D);
        prog.delete();
        prog.push_back(32'hAC22_0000);
        prog.push_back(HALT);
        setup_program();
        exec("mis", cyc);

        // Random programs, random wait states, stray acks and ignored preloads while busy
        for (int it = 0; it < 6; it++) begin
            do_reset();
            ack_mode = -1;
            spurious = 1'b1;
            garbage  = 1'b1;
            for (int r = 0; r < 8; r++) begin
                v = $urandom;
                if ($urandom_range(0, 7) != 0) v = v & 32'hFFFF_FFFC;
                preload(r, v);
            end
            prog.delete();
            n = int'($urandom_range(1, 8));
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 9) == 0) begin
                    op = 6'($urandom_range(0, 42));
                    prog.push_back({op, 26'($urandom)});
                end else begin
                    rs  = int'($urandom_range(0, 7));
                    rt  = int'($urandom_range(0, 7));
                    imm = 16'($urandom);
                    if ($urandom_range(0, 7) != 0) imm = imm & 16'hFFFC;
                    prog.push_back(enc_sw(rt, rs, imm));
                end
            end
            prog.push_back(HALT);
            setup_program();
            exec("rnd", cyc);
        end
        spurious = 1'b0;
        garbage  = 1'b0;

        // Reset while a store is waiting for ack
        do_reset();
        ack_mode = 0;
        preload(1, 32'h0000_0100);
        preload(2, 32'h0000_0005);
        prog.delete();
        prog.push_back(32'hAC22_0008);
        prog.push_back(32'hAC22_000C);
        prog.push_back(HALT);
        setup_program();
        @(negedge clk);
        run = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (retired == 16'd1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_err++;
            $display("FAIL rstw_first_store: got retired %0d, expected 1 within 200 cycles", retired);
        end
        ack_mode = 40;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mem_req && mem_we) begin
                got = 1'b1;
                break;
            end
        end
        chk("rstw_in_memwr", 32'(got), 32'h1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        run = 1'b0;
        #1;
        chk("rstw_req", 32'(mem_req), 32'h0);
        chk("rstw_we", 32'(mem_we), 32'h0);
        chk("rstw_pc", pc_out, 32'h0);
        chk("rstw_retired", 32'(retired), 32'h0);
        sb.delete();
        @(negedge clk);
        rst      = 1'b0;
        ack_mode = 0;
        repeat (3) @(negedge clk);
        chk("rstw_stays_idle", 32'(mem_req), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
